ddr_port_arbiter: RTL

- Sits between the MIG DDR3 user interface (ui_clk domain) and two requesters: the fractal pixel writer (single 128-bit write beats) and the VGA line prefetcher (short read bursts).
- Owns app_en, app_cmd, app_addr and app_wdf_* exclusively.
- Sequences each MIG handshake and returns read data in order.
- Reads have priority so the display never underruns; writes fill the gaps.

---
 rtl/ddr_arb_pkg.sv | 23 ++
 rtl/ddr_rd_addr_gen.sv | 43 ++++
 rtl/ddr_port_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and constants for the DDR port arbiter
//
// Purpose : arbiter state encoding, MIG command codes and default address
//           stepping / frame wrap constants used by the arbiter and its
//           read address generator.
// Ports   : none (package).
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_RD_DRAIN
  } arb_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int DEF_ADDR_STEP  = 8;
  localparam int DEF_FRAME_LAST = 786424;

endpackage

// File: rtl/ddr_rd_addr_gen.sv
// rtl/ddr_rd_addr_gen.sv - MIG command address register with burst step/wrap and issue counter
//
// Purpose : holds the address presented on app_addr. A grant loads it (read
//           start address or write beat address); each accepted read command
//           advances it by ADDR_STEP, wrapping to 0 after FRAME_LAST, and
//           counts the commands issued in the current burst.
// Ports   : ui_clk, sys_rst_n   clock / async active-low reset
//           load, load_addr     load a new address and clear the counter
//           step                one read command accepted this cycle
//           addr                current command address
//           issued              read commands accepted since the last load
module ddr_rd_addr_gen
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int LEN_W      = 4,
  parameter int ADDR_STEP  = DEF_ADDR_STEP,
  parameter int FRAME_LAST = DEF_FRAME_LAST
) (
  input  logic              ui_clk,
  input  logic              sys_rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [LEN_W:0]    issued
);

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr   <= '0;
      issued <= '0;
    end else if (load) begin
      addr   <= load_addr;
      issued <= '0;
    end else if (step) begin
      issued <= issued + 1'b1;
      // The frame buffer is scanned circularly, so a burst may straddle the end.
      addr   <= (addr == ADDR_W'(FRAME_LAST)) ? '0 : addr + ADDR_W'(ADDR_STEP);
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - two-port (pixel write / line read) arbiter in front of the MIG UI
//
// Purpose : owns the MIG app_* command and write-data interface, sequencing
//           single-beat writes from the pixel writer and short read bursts
//           from the VGA prefetcher. Reads win arbitration; read data is
//           returned in order and writes never interleave with a burst.
// Ports   : ui_clk, sys_rst_n, calib_done          clock, async reset, MIG calibration
//           wr_req/wr_addr/wr_data -> wr_ack       write port (single 128-bit beat)
//           rd_req/rd_addr/rd_len  -> rd_ack       read request port
//           rd_data/rd_valid/rd_done               read return stream
//           busy, err_unexp                        status
//           app_*                                  MIG user interface
// Config  : `define WR_STARVE_GUARD_EN to force a pending write through after
//           STARVE_LIMIT consecutive read grants; otherwise reads have strict priority.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W       = 28,
  parameter int DATA_W       = 128,
  parameter int LEN_W        = 4,
  parameter int BURST_MAX    = 10,
  parameter int ADDR_STEP    = DEF_ADDR_STEP,
  parameter int FRAME_LAST   = DEF_FRAME_LAST,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              ui_clk,
  input  logic              sys_rst_n,
  input  logic              calib_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_done,
  output logic              busy,
  output logic              err_unexp,
  output logic [ADDR_W-1:0] app_addr,
  output logic [2:0]        app_cmd,
  output logic              app_en,
  input  logic              app_rdy,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid
);

  arb_state_t        state;
  logic [LEN_W:0]    len_q;
  logic [LEN_W:0]    returned;
  logic              ret_done;
  logic [LEN_W:0]    issued;
  logic              starve_force;
  logic              rd_win;
  logic              wr_win;
  logic              gen_load;
  logic              gen_step;

  function automatic logic [LEN_W:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] l;
    l = {1'b0, len};
    if (l == '0) return (LEN_W+1)'(1);
    if (l > (LEN_W+1)'(BURST_MAX)) return (LEN_W+1)'(BURST_MAX);
    return l;
  endfunction

  // A forced write only overrides the read while that write is still pending.
  always_comb begin
    rd_win = rd_req && !(starve_force && wr_req);
    wr_win = wr_req && !rd_win;
  end

  assign gen_load = (state == ST_IDLE) && (rd_win || wr_win);
  assign gen_step = (state == ST_RD_ISSUE) && app_en && app_rdy;

  ddr_rd_addr_gen #(
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .ADDR_STEP  (ADDR_STEP),
    .FRAME_LAST (FRAME_LAST)
  ) u_addr_gen (
    .ui_clk    (ui_clk),
    .sys_rst_n (sys_rst_n),
    .load      (gen_load),
    .load_addr (rd_win ? rd_addr : wr_addr),
    .step      (gen_step),
    .addr      (app_addr),
    .issued    (issued)
  );

`ifdef WR_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  assign starve_force = (starve_cnt >= SC_W'(STARVE_LIMIT));

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      starve_cnt <= '0;
    end else if (!wr_req || (state == ST_IDLE && wr_win)) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE && rd_win) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= ST_INIT;
      len_q        <= '0;
      returned     <= '0;
      ret_done     <= 1'b0;
      wr_ack       <= 1'b0;
      rd_ack       <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      rd_done      <= 1'b0;
      busy         <= 1'b0;
      err_unexp    <= 1'b0;
      app_cmd      <= '0;
      app_en       <= 1'b0;
      app_wdf_data <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_end  <= 1'b0;
    end else begin
      app_wdf_end <= 1'b1;
      wr_ack      <= 1'b0;
      rd_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_done     <= 1'b0;
      busy        <= 1'b1;

      case (state)
        ST_INIT: begin
          if (calib_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        ST_IDLE: begin
          if (rd_win) begin
            rd_ack   <= 1'b1;
            len_q    <= clamp_len(rd_len);
            returned <= '0;
            ret_done <= 1'b0;
            app_cmd  <= CMD_READ;
            app_en   <= 1'b1;
            state    <= ST_RD_ISSUE;
          end else if (wr_win) begin
            app_cmd      <= CMD_WRITE;
            app_en       <= 1'b1;
            app_wdf_data <= wr_data;
            app_wdf_wren <= 1'b1;
            state        <= ST_WR_ISSUE;
          end else begin
            busy <= 1'b0;
          end
        end

        ST_WR_ISSUE: begin
          // Command and data channels complete independently in the MIG.
          if (app_en && app_rdy) app_en <= 1'b0;
          if (app_wdf_wren && app_wdf_rdy) app_wdf_wren <= 1'b0;
          if (!app_en && !app_wdf_wren) begin
            wr_ack <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end

        ST_RD_ISSUE: begin
          if (gen_step && (issued + 1'b1 == len_q)) begin
            app_en <= 1'b0;
            state  <= ST_RD_DRAIN;
          end
        end

        ST_RD_DRAIN: begin
          if (ret_done) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_INIT;
      endcase

      // Beats can come back while later commands of the burst are still issuing.
      if ((state == ST_RD_ISSUE || state == ST_RD_DRAIN) && app_rd_data_valid && returned < len_q) begin
        rd_data  <= app_rd_data;
        rd_valid <= 1'b1;
        returned <= returned + 1'b1;
        if (returned + 1'b1 == len_q) begin
          rd_done  <= 1'b1;
          ret_done <= 1'b1;
        end
      end

      if ((state == ST_IDLE || state == ST_WR_ISSUE) && app_rd_data_valid) begin
        err_unexp <= 1'b1;
      end
    end
  end

endmodule
